// File: rtl/if_id_queue_if.sv
// IF->ID queue handshake bundle: push side from IF, pop side to ID.
// The queue takes the slave modport; the fetch/decode side takes master.
interface if_id_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_taken;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_taken;

  modport master (
    output in_valid, in_pc, in_inst, in_taken,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_taken
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_taken,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_inst, out_taken
  );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {pc, inst, taken} decoupling IF from ID.
// Empty head reads as an all-zero bubble.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  if_id_queue_if.slave     q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [INST_W-1:0] inst_q  [DEPTH];
  logic              taken_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign q.in_ready  = (count_q != FULL);
  assign q.out_valid = (count_q != '0);

  assign push = q.in_valid & q.in_ready
              & rdy & ~flush & ~rst;
  assign pop  = q.out_valid & q.out_ready
              & ~stall & rdy & ~flush & ~rst;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= q.in_pc;
      inst_q[wr_ptr_q]  <= q.in_inst;
      taken_q[wr_ptr_q] <= q.in_taken;
    end
  end

  assign q.out_pc    = q.out_valid ? pc_q[rd_ptr_q]    : '0;
  assign q.out_inst  = q.out_valid ? inst_q[rd_ptr_q]  : '0;
  assign q.out_taken = q.out_valid ? taken_q[rd_ptr_q] : 1'b0;
  assign count       = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
  } ent_t;

  logic clk = 0;
  logic rst, rdy, stall, flush;
  logic [CNT_W-1:0] count;
  int checks = 0;
  int errors = 0;
  ent_t mq[$];

  if_id_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_id_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .stall(stall), .flush(flush),
    .count(count), .q(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h.pc = '0; h.inst = '0; h.taken = 1'b0;
    if (mq.size() != 0) h = mq[0];
    chk("count",     64'(count),         64'(mq.size()));
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() < DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("out_pc",    64'(bus.out_pc),    64'(h.pc));
    chk("out_inst",  64'(bus.out_inst),  64'(h.inst));
    chk("out_taken", 64'(bus.out_taken), 64'(h.taken));
  endtask

  // Apply one cycle of inputs and advance the model for the next edge.
  task automatic step(bit do_chk, bit r, bit y, bit f, bit s,
                      bit iv, logic [31:0] pc, logic [31:0] inst,
                      bit tk, bit ordy);
    bit pu, po;
    ent_t e;
    @(negedge clk);
    if (do_chk) check_all();
    rst = r; rdy = y; flush = f; stall = s;
    bus.in_valid = iv; bus.in_pc = pc;
    bus.in_inst = inst; bus.in_taken = tk;
    bus.out_ready = ordy;
    if (r) mq.delete();
    else if (!y) ;
    else if (f) mq.delete();
    else begin
      pu = iv && (mq.size() < DEPTH);
      po = ordy && !s && (mq.size() != 0);
      if (po) void'(mq.pop_front());
      if (pu) begin
        e.pc = pc; e.inst = inst; e.taken = tk;
        mq.push_back(e);
      end
    end
  endtask

  task automatic push(logic [31:0] pc, logic [31:0] inst, bit ordy);
    step(1, 0, 1, 0, 0, 1, pc, inst, pc[2], ordy);
  endtask

  task automatic idle(bit ordy);
    step(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, ordy);
  endtask

  initial begin
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    // fill three, then two more with head held
    push(32'h100, 32'hA, 0);
    push(32'h104, 32'hB, 0);
    push(32'h108, 32'hC, 0);
    push(32'h10C, 32'hD, 0);
    push(32'h110, 32'hE, 0);
    chk("full_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < 5; i++) idle(1);
    idle(0);
    chk("drain_bubble", 64'(bus.out_pc), 64'h0);
    // full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(32'h120 + 4*i, 32'h20 + i, 0);
    push(32'h140, 32'h40, 1);
    push(32'h140, 32'h40, 0);
    idle(0);
    for (int i = 0; i < 4; i++) idle(1);
    // stall holds head while pushes proceed
    push(32'h150, 32'h50, 0);
    push(32'h154, 32'h51, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1, 1, 32'h158, 32'h52, 1, 1);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(1);
    // flush drops contents and a same-cycle push
    push(32'h160, 32'h60, 0);
    push(32'h164, 32'h61, 0);
    push(32'h168, 32'h62, 0);
    step(1, 0, 1, 1, 0, 1, 32'h200, 32'h70, 1, 1);
    push(32'h300, 32'h80, 0);
    idle(0);
    chk("post_flush_head", 64'(bus.out_pc), 64'h300);
    // rdy freeze, then reset mid-stream
    push(32'h304, 32'h81, 0);
    step(1, 0, 0, 0, 0, 1, 32'h400, 32'h90, 0, 1);
    step(1, 0, 0, 1, 0, 1, 32'h404, 32'h91, 0, 1);
    step(1, 1, 1, 0, 0, 1, 32'h408, 32'h92, 0, 1);
    idle(0);
    chk("rst_count", 64'(count), 64'h0);
    // random traffic with phases favouring fill or drain
    for (int i = 0; i < 1500; i++) begin
      int ph;
      ph = (i / 100) % 3;
      step(1,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) < (ph == 1 ? 1 : 3),
           $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 3) < (ph == 0 ? 1 : 3));
    end
    idle(0);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, inst, taken} between IF and ID.
- Lets IF keep fetching while ID is stalled.
- Supports flush on branch mispredict, ctrl-driven ID stall, and a global rdy freeze.
- The empty-queue output is a zero bubble: pc=0, inst=0, taken=0.

Parameters:
ADDR_W, 32, width of pc fields
INST_W, 32, width of instruction fields
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
rdy  input  1  global ready; low freezes all state
in_valid  input  1  IF presents an instruction this cycle
in_ready  output  1  queue can accept a push (combinational)
in_pc  input  ADDR_W  fetched pc
in_inst  input  INST_W  fetched instruction
in_taken  input  1  IF branch-prediction taken flag
out_valid  output  1  head entry valid (combinational from state)
out_ready  input  1  ID consumes head this cycle
out_pc  output  ADDR_W  head pc, 0 when empty
out_inst  output  INST_W  head instruction, 0 when empty
out_taken  output  1  head taken flag, 0 when empty
stall  input  1  ctrl holds ID; blocks pop
flush  input  1  discard all entries (mispredict/jump)
count  output  CNT_W  current occupancy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Priority per rising edge: rst > !rdy > flush > push/pop.
- rst=1:
  - rd_ptr, wr_ptr and count cleared to 0.
  - Outputs next cycle: out_valid=0, out_pc=0, out_inst=0, out_taken=0, count=0, in_ready=1.
  - Storage contents need not be cleared.
- rdy=0 (rst=0):
  - No state change; push and pop both ignored.
  - in_ready still reflects count.
- flush=1 (rst=0, rdy=1):
  - Pointers and count cleared.
  - A same-cycle push is discarded and a same-cycle pop is ignored.
  - out_valid=0 from the next cycle.
- Push condition: in_valid && in_ready && rdy && !flush && !rst.
  - Writes {in_pc, in_inst, in_taken} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop condition: out_valid && out_ready && !stall && rdy && !flush && !rst.
  - rd_ptr increments modulo DEPTH.
- Flags and count:
  - in_ready = (count != DEPTH). There is no full-bypass: when full, a push is refused even if a pop occurs the same cycle.
  - out_valid = (count != 0).
  - Output fields come from storage at rd_ptr when out_valid=1, otherwise forced to 0.
  - count next = count + push - pop. Simultaneous push and pop leaves count unchanged; never over- or underflows.
- Latency:
  - A pushed entry is visible at the outputs the cycle after the push edge; there is no same-cycle fall-through when empty.
  - Entries leave in strict FIFO order.
- Pointer wrap:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by count, not by pointer equality.
- stall=1 holds head outputs stable. Pushes still proceed while in_ready=1.
- Reset or flush mid-stream:
  - All in-flight entries are lost.
  - The first push after clear lands in entry 0 and appears alone at the head.

Test Plan:
- Reset, then push pc=0x100/0x104/0x108 with inst=0xA,0xB,0xC and out_ready=0 -> count=3; out_pc=0x100, out_inst=0xA held; in_ready=1.
- DEPTH=4: push 5 consecutive with out_ready=0 -> count saturates at 4, in_ready=0 on the 5th cycle, 5th entry not stored. Then pop all with out_ready=1 -> pcs 0x100..0x10C in order, then out_valid=0 and outputs 0.
- Full queue, in_valid=1, out_ready=1 same cycle -> pop occurs, push refused, count 4->3; next cycle in_ready=1 and the push is accepted.
- Queue count=2, stall=1 with out_ready=1 for 3 cycles plus one push -> no pop, count=3, head unchanged; release stall -> pops resume in order.
- count=3, flush=1 with in_valid=1 (pc=0x200) -> next cycle count=0, out_valid=0, outputs 0. Following push pc=0x300 appears at the head one cycle later.
- rdy=0 for 2 cycles with in_valid=1 and out_ready=1 -> count and outputs frozen. rst=1 asserted mid-stream with count=2 -> next cycle count=0, out_valid=0, in_ready=1.
